id_ex_pipeline_register: RTL and testbench

//  ID/EX boundary register of the 5-stage MIPS pipeline. Captures decoded control, register

---
 rtl/id_ex_pipeline_register_pkg.sv | 37 +++
 rtl/id_ex_pipeline_register_if.sv | 75 +++++++
 rtl/id_ex_pipeline_register_pipe_reg.sv | 23 ++
 rtl/id_ex_pipeline_register.sv | 105 ++++++++++
 tb/tb_id_ex_pipeline_register.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipeline_register_pkg.sv
// ID/EX boundary shared types: ALUOp and funct codes, control bundle.
// Imported by the register, its flop bank users and the bench.
package id_ex_pipeline_register_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 16;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       memto_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_WIDTH = $bits(ctrl_t);

  // An all-zero bundle is a bubble: no writes, no branch, ALUOp add.
  function automatic ctrl_t gate_ctrl(ctrl_t c);
    return c.valid ? c : '0;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_register_if.sv
// ID/EX bus: id_* fields from decode, ex_* registered copies to EX.
// master drives id_* and reads ex_*; slave is the register itself.
interface id_ex_pipeline_register_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      id_valid;
  logic                      id_RegWrite;
  logic                      id_MemtoReg;
  logic                      id_Branch;
  logic                      id_MemRead;
  logic                      id_MemWrite;
  logic                      id_RegDst;
  logic                      id_ALUSrc;
  logic [1:0]                id_ALUOp;
  logic [DATA_WIDTH-1:0]     id_pc_plus4;
  logic [DATA_WIDTH-1:0]     id_read_data1;
  logic [DATA_WIDTH-1:0]     id_read_data2;
  logic [DATA_WIDTH-1:0]     id_sign_ext_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;

  logic                      ex_valid;
  logic                      ex_RegWrite;
  logic                      ex_MemtoReg;
  logic                      ex_Branch;
  logic                      ex_MemRead;
  logic                      ex_MemWrite;
  logic                      ex_RegDst;
  logic                      ex_ALUSrc;
  logic [1:0]                ex_ALUOp;
  logic [DATA_WIDTH-1:0]     ex_pc_plus4;
  logic [DATA_WIDTH-1:0]     ex_read_data1;
  logic [DATA_WIDTH-1:0]     ex_read_data2;
  logic [DATA_WIDTH-1:0]     ex_sign_ext_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [5:0]                ex_funct;
  logic [CNT_WIDTH-1:0]      ex_bubble_count;

  modport master (
    output id_valid, id_RegWrite, id_MemtoReg,
    output id_Branch, id_MemRead, id_MemWrite,
    output id_RegDst, id_ALUSrc, id_ALUOp,
    output id_pc_plus4, id_read_data1,
    output id_read_data2, id_sign_ext_imm,
    output id_rs, id_rt, id_rd,
    input  ex_valid, ex_RegWrite, ex_MemtoReg,
    input  ex_Branch, ex_MemRead, ex_MemWrite,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp,
    input  ex_pc_plus4, ex_read_data1,
    input  ex_read_data2, ex_sign_ext_imm,
    input  ex_rs, ex_rt, ex_rd,
    input  ex_funct, ex_bubble_count
  );

  modport slave (
    input  id_valid, id_RegWrite, id_MemtoReg,
    input  id_Branch, id_MemRead, id_MemWrite,
    input  id_RegDst, id_ALUSrc, id_ALUOp,
    input  id_pc_plus4, id_read_data1,
    input  id_read_data2, id_sign_ext_imm,
    input  id_rs, id_rt, id_rd,
    output ex_valid, ex_RegWrite, ex_MemtoReg,
    output ex_Branch, ex_MemRead, ex_MemWrite,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp,
    output ex_pc_plus4, ex_read_data1,
    output ex_read_data2, ex_sign_ext_imm,
    output ex_rs, ex_rt, ex_rd,
    output ex_funct, ex_bubble_count
  );
endinterface

// File: rtl/id_ex_pipeline_register_pipe_reg.sv
// pipe_reg: W-bit flop bank, async active-high reset, sync clear, enable.
// Ports: clk, rst, en (load), clr (zero, beats en), d, q.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with stall hold, flush bubble, bubble counter.
// Ports: clk, reset (async high), stall, flush, bus (slave: id_* in, ex_* out).
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  id_ex_pipeline_register_if.slave bus
);

  localparam int DBW = 4*DATA_WIDTH + 3*REG_ADDR_WIDTH;

  ctrl_t          id_ctrl;
  ctrl_t          ctrl_d;
  ctrl_t          ctrl_q;
  logic [DBW-1:0] data_d;
  logic [DBW-1:0] data_q;
  logic           bubble;
  logic [CNT_WIDTH-1:0] cnt;

  always_comb begin
    id_ctrl           = '0;
    id_ctrl.valid     = bus.id_valid;
    id_ctrl.reg_write = bus.id_RegWrite;
    id_ctrl.memto_reg = bus.id_MemtoReg;
    id_ctrl.branch    = bus.id_Branch;
    id_ctrl.mem_read  = bus.id_MemRead;
    id_ctrl.mem_write = bus.id_MemWrite;
    id_ctrl.reg_dst   = bus.id_RegDst;
    id_ctrl.alu_src   = bus.id_ALUSrc;
    id_ctrl.alu_op    = bus.id_ALUOp;
  end

  // Invalid ID slot loads its data but never its controls.
  assign ctrl_d = gate_ctrl(id_ctrl);

  assign data_d = {
    bus.id_pc_plus4,
    bus.id_read_data1,
    bus.id_read_data2,
    bus.id_sign_ext_imm,
    bus.id_rs,
    bus.id_rt,
    bus.id_rd
  };

  pipe_reg #(.W(CTRL_WIDTH)) u_ctrl (
    .clk (clk),
    .rst (reset),
    .en  (~stall),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_reg #(.W(DBW)) u_data (
    .clk (clk),
    .rst (reset),
    .en  (~stall),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  assign bus.ex_valid    = ctrl_q.valid;
  assign bus.ex_RegWrite = ctrl_q.reg_write;
  assign bus.ex_MemtoReg = ctrl_q.memto_reg;
  assign bus.ex_Branch   = ctrl_q.branch;
  assign bus.ex_MemRead  = ctrl_q.mem_read;
  assign bus.ex_MemWrite = ctrl_q.mem_write;
  assign bus.ex_RegDst   = ctrl_q.reg_dst;
  assign bus.ex_ALUSrc   = ctrl_q.alu_src;
  assign bus.ex_ALUOp    = ctrl_q.alu_op;

  assign {
    bus.ex_pc_plus4,
    bus.ex_read_data1,
    bus.ex_read_data2,
    bus.ex_sign_ext_imm,
    bus.ex_rs,
    bus.ex_rt,
    bus.ex_rd
  } = data_q;

  assign bus.ex_funct = bus.ex_sign_ext_imm[5:0];

  // A flush always bubbles; a stalled cycle inserts nothing.
  assign bubble = flush | (~stall & ~bus.id_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (bubble && (cnt != '1))
      cnt <= cnt + CNT_WIDTH'(1);
  end

  assign bus.ex_bubble_count = cnt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register.
// Hand-computed vectors checked with immediate assertions.
module tb_id_ex_pipeline_register;
  import id_ex_pipeline_register_pkg::*;

  logic clk;
  logic reset;
  logic stall;
  logic flush;
  int   vectors;
  int   miscompares;

  id_ex_pipeline_register_if #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)
  ) bus ();

  id_ex_pipeline_register #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [7:0] c, input logic [1:0] op);
    bus.id_valid        = v;
    bus.id_RegWrite     = c[7];
    bus.id_MemtoReg     = c[6];
    bus.id_Branch       = c[5];
    bus.id_MemRead      = c[4];
    bus.id_MemWrite     = c[3];
    bus.id_RegDst       = c[2];
    bus.id_ALUSrc       = c[1];
    bus.id_ALUOp        = op;
    bus.id_pc_plus4     = pc;
    bus.id_read_data1   = rd1;
    bus.id_read_data2   = rd2;
    bus.id_sign_ext_imm = imm;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_rd           = rd;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 8'h00, 2'b00);
    step();
    step();
    reset = 1'b0;

    // reset mid-load clears everything before the next edge
    drive(1'b1, '1, '1, '1, '1, '1, '1, '1, 8'hFF, 2'b11);
    step();
    chk("load_ones_pc", bus.ex_pc_plus4, 32'hFFFFFFFF);
    chk("load_ones_op", bus.ex_ALUOp, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", bus.ex_valid, 1'b0);
    chk("rst_regwrite", bus.ex_RegWrite, 1'b0);
    chk("rst_aluop", bus.ex_ALUOp, 2'b00);
    chk("rst_rd1", bus.ex_read_data1, 32'h0);
    chk("rst_rs", bus.ex_rs, 5'd0);
    chk("rst_cnt", bus.ex_bubble_count, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // R-type AND: funct comes from imm[5:0]
    drive(1'b1, 32'h4, 32'h5, 32'h6, 32'h00000024,
          5'd8, 5'd9, 5'd10, 8'h84, ALUOP_RTYPE);
    step();
    chk("funct", bus.ex_funct, FUNCT_AND);
    chk("rs", bus.ex_rs, 5'd8);
    chk("rtype_op", bus.ex_ALUOp, ALUOP_RTYPE);
    chk("rtype_cnt", bus.ex_bubble_count, 16'h0);

    // load A, then stall 3 cycles while presenting B
    drive(1'b1, 32'h100, 32'h11111111, 32'h1, 32'h20,
          5'd1, 5'd2, 5'd3, 8'h80, ALUOP_ADD);
    step();
    chk("a_pc", bus.ex_pc_plus4, 32'h100);
    stall = 1'b1;
    drive(1'b1, 32'h200, 32'h22222222, 32'h2, 32'h22,
          5'd4, 5'd5, 5'd6, 8'h10, ALUOP_SUB);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", bus.ex_pc_plus4, 32'h100);
      chk("hold_rd1", bus.ex_read_data1, 32'h11111111);
      chk("hold_regw", bus.ex_RegWrite, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("b_pc", bus.ex_pc_plus4, 32'h200);
    chk("b_memread", bus.ex_MemRead, 1'b1);
    chk("b_op", bus.ex_ALUOp, ALUOP_SUB);
    chk("b_funct", bus.ex_funct, FUNCT_SUB);

    // flush beats stall
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h300, 32'h3, 32'h3, 32'h3,
          5'd7, 5'd7, 5'd7, 8'h80, ALUOP_RTYPE);
    step();
    chk("fl_valid", bus.ex_valid, 1'b0);
    chk("fl_regw", bus.ex_RegWrite, 1'b0);
    chk("fl_pc", bus.ex_pc_plus4, 32'h0);
    chk("fl_cnt", bus.ex_bubble_count, 16'h1);

    // invalid slot: data loads, controls gated, counts a bubble
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h400, 32'h4, 32'hDEADBEEF, 32'h4,
          5'd1, 5'd1, 5'd1, 8'h08, ALUOP_RTYPE);
    step();
    chk("inv_memw", bus.ex_MemWrite, 1'b0);
    chk("inv_rd2", bus.ex_read_data2, 32'hDEADBEEF);
    chk("inv_op", bus.ex_ALUOp, 2'b00);
    chk("inv_cnt", bus.ex_bubble_count, 16'h2);

    // stalled invalid slot is not a bubble
    stall = 1'b1;
    drive(1'b0, 32'h500, 32'h5, 32'h5, 32'h5,
          5'd2, 5'd2, 5'd2, 8'h00, ALUOP_ADD);
    step();
    chk("stinv_cnt", bus.ex_bubble_count, 16'h2);
    chk("stinv_rd2", bus.ex_read_data2, 32'hDEADBEEF);

    // saturation: 65532 flushes to reach 0xFFFE
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h600, 32'h6, 32'h6, 32'h6,
          5'd3, 5'd3, 5'd3, 8'hB8, ALUOP_ADD);
    repeat (65532) @(posedge clk);
    #1;
    chk("sat_fffe", bus.ex_bubble_count, 16'hFFFE);
    chk("sat_memr", bus.ex_MemRead, 1'b0);
    chk("sat_branch", bus.ex_Branch, 1'b0);
    step();
    chk("sat_ffff", bus.ex_bubble_count, 16'hFFFF);
    step();
    chk("sat_hold", bus.ex_bubble_count, 16'hFFFF);

    // reset during stall clears counter and contents
    flush = 1'b0;
    drive(1'b1, 32'h700, 32'h7, 32'h7, 32'h7,
          5'd4, 5'd4, 5'd4, 8'h80, ALUOP_ADD);
    step();
    chk("pre_rst_pc", bus.ex_pc_plus4, 32'h700);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_st_cnt", bus.ex_bubble_count, 16'h0);
    chk("rst_st_pc", bus.ex_pc_plus4, 32'h0);
    chk("rst_st_regw", bus.ex_RegWrite, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
